// File: rtl/game_pkg.sv
// Shared constants and types for the game input path.
// Button indices, default timing and the fire strike FSM encoding.
package game_pkg;

   localparam int BTN_TICK_DIV    = 25000;
   localparam int BTN_DEBOUNCE_MS = 10;
   localparam int BTN_AUTOFIRE_MS = 200;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_FIRE  = 2;
   localparam int BTN_COUNT = 3;

   typedef enum logic {
      FIRE_IDLE = 1'b0,
      FIRE_HELD = 1'b1
   } fire_state_t;

endpackage

// File: rtl/debounce_cell.sv
// One button: two-flop synchroniser followed by a tick-paced debounce
// counter; the level only moves after DEBOUNCE_MS stable ms ticks.
module debounce_cell #(
   parameter int DEBOUNCE_MS = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic i_tick,
   input  logic i_raw,
   output logic o_db
);

   localparam int CW = $clog2(DEBOUNCE_MS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_db;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_db  <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
         // any agreement with the held level restarts the stability count
         if (r_s2 == r_db) begin
            r_cnt <= '0;
         end else if (i_tick) begin
            if (r_cnt == CNT_LAST) begin
               r_db  <= ~r_db;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign o_db = r_db;

endmodule

// File: rtl/button_conditioner.sv
// Debounced buttons, movement levels, fire strike and 1 ms tick.
// Optional autofire repeat when BUTTON_AUTOFIRE_EN is defined.
module button_conditioner
   import game_pkg::*;
#(
   parameter int TICK_DIV    = BTN_TICK_DIV,
   parameter int DEBOUNCE_MS = BTN_DEBOUNCE_MS,
   parameter int AUTOFIRE_MS = BTN_AUTOFIRE_MS
) (
   input  logic clk,
   input  logic reset,
   input  logic upButton,
   input  logic downButton,
   input  logic fireButton,
   output logic up_db,
   output logic down_db,
   output logic fire_db,
   output logic up_move,
   output logic down_move,
   output logic fire_pulse,
   output logic ms_tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   if (TICK_DIV < 2 || DEBOUNCE_MS < 1 || AUTOFIRE_MS < 1) begin : g_bad_param
      $error("button_conditioner: parameter out of range");
   end

   logic [PW-1:0]        r_pre;
   logic                 r_ms_tick;
   logic [BTN_COUNT-1:0] w_raw;
   logic [BTN_COUNT-1:0] w_db;
   fire_state_t          r_state;
   logic                 r_fire_pulse;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pre     <= '0;
         r_ms_tick <= 1'b0;
      end else if (r_pre == PRE_LAST) begin
         r_pre     <= '0;
         r_ms_tick <= 1'b1;
      end else begin
         r_pre     <= r_pre + PW'(1);
         r_ms_tick <= 1'b0;
      end
   end

   assign w_raw[BTN_UP]   = upButton;
   assign w_raw[BTN_DOWN] = downButton;
   assign w_raw[BTN_FIRE] = fireButton;

   for (genvar g = 0; g < BTN_COUNT; g++) begin : g_cell
      debounce_cell #(
         .DEBOUNCE_MS(DEBOUNCE_MS)
      ) u_cell (
         .clk    (clk),
         .reset  (reset),
         .i_tick (r_ms_tick),
         .i_raw  (w_raw[g]),
         .o_db   (w_db[g])
      );
   end

`ifdef BUTTON_AUTOFIRE_EN
   localparam int AW = (AUTOFIRE_MS > 1) ? $clog2(AUTOFIRE_MS) : 1;
   localparam logic [AW-1:0] REP_LAST = AW'(AUTOFIRE_MS - 1);

   logic [AW-1:0] r_rep;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= FIRE_IDLE;
         r_fire_pulse <= 1'b0;
         r_rep        <= '0;
      end else begin
         r_fire_pulse <= 1'b0;
         unique case (r_state)
            FIRE_IDLE: begin
               r_rep <= '0;
               if (w_db[BTN_FIRE]) begin
                  r_state      <= FIRE_HELD;
                  r_fire_pulse <= 1'b1;
               end
            end
            FIRE_HELD: begin
               if (!w_db[BTN_FIRE]) begin
                  r_state <= FIRE_IDLE;
                  r_rep   <= '0;
               end else if (r_ms_tick) begin
                  if (r_rep == REP_LAST) begin
                     r_fire_pulse <= 1'b1;
                     r_rep        <= '0;
                  end else begin
                     r_rep <= r_rep + AW'(1);
                  end
               end
            end
         endcase
      end
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= FIRE_IDLE;
         r_fire_pulse <= 1'b0;
      end else begin
         r_fire_pulse <= 1'b0;
         unique case (r_state)
            FIRE_IDLE: begin
               if (w_db[BTN_FIRE]) begin
                  r_state      <= FIRE_HELD;
                  r_fire_pulse <= 1'b1;
               end
            end
            FIRE_HELD: begin
               if (!w_db[BTN_FIRE]) begin
                  r_state <= FIRE_IDLE;
               end
            end
         endcase
      end
   end
`endif

   assign up_db      = w_db[BTN_UP];
   assign down_db    = w_db[BTN_DOWN];
   assign fire_db    = w_db[BTN_FIRE];
   // pressing both directions cancels movement but still reports both levels
   assign up_move    = w_db[BTN_UP] & ~w_db[BTN_DOWN];
   assign down_move  = w_db[BTN_DOWN] & ~w_db[BTN_UP];
   assign fire_pulse = r_fire_pulse;
   assign ms_tick    = r_ms_tick;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: cycle model plus directed latency checks.
// Build with BUTTON_AUTOFIRE_EN to exercise the repeat pulses.
module tb_button_conditioner;

   localparam int TD = 4;
   localparam int DB = 3;
   localparam int AF = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic upButton = 1'b0;
   logic downButton = 1'b0;
   logic fireButton = 1'b0;
   logic up_db, down_db, fire_db, up_move, down_move, fire_pulse, ms_tick;
   logic [2:0] raw;

   always #5 clk = ~clk;

   assign raw = {fireButton, downButton, upButton};

   button_conditioner #(
      .TICK_DIV(TD),
      .DEBOUNCE_MS(DB),
      .AUTOFIRE_MS(AF)
   ) dut (
      .clk(clk),
      .reset(reset),
      .upButton(upButton),
      .downButton(downButton),
      .fireButton(fireButton),
      .up_db(up_db),
      .down_db(down_db),
      .fire_db(fire_db),
      .up_move(up_move),
      .down_move(down_move),
      .fire_pulse(fire_pulse),
      .ms_tick(ms_tick)
   );

   // Model: a level is accepted only after DB ms ticks in a row on which
   // the synchronised input disagreed with the current level.
   typedef struct packed {
      logic [7:0]      pc;
      logic            tick;
      logic [2:0]      s1;
      logic [2:0]      s2;
      logic [2:0]      db;
      logic [2:0][7:0] run;
      logic            held;
      logic            pulse;
      logic [7:0]      rep;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t mdl_next(input mdl_t c, input logic [2:0] r);
      mdl_t n;
      n = c;
      n.tick = (c.pc == 8'(TD - 1));
      n.pc = n.tick ? 8'd0 : c.pc + 8'd1;
      for (int b = 0; b < 3; b++) begin
         n.s1[b] = r[b];
         n.s2[b] = c.s1[b];
         if (c.s2[b] == c.db[b]) begin
            n.run[b] = 8'd0;
         end else if (c.tick) begin
            if (c.run[b] + 8'd1 == 8'(DB)) begin
               n.db[b] = ~c.db[b];
               n.run[b] = 8'd0;
            end else begin
               n.run[b] = c.run[b] + 8'd1;
            end
         end
      end
      n.pulse = 1'b0;
      if (!c.held) begin
         n.rep = 8'd0;
         n.held = c.db[2];
         n.pulse = c.db[2];
      end else if (!c.db[2]) begin
         n.held = 1'b0;
         n.rep = 8'd0;
      end
`ifdef BUTTON_AUTOFIRE_EN
      else if (c.tick) begin
         if (c.rep == 8'(AF - 1)) begin
            n.pulse = 1'b1;
            n.rep = 8'd0;
         end else begin
            n.rep = c.rep + 8'd1;
         end
      end
`endif
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) m <= '0;
      else m <= mdl_next(m, raw);
   end

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   int fdb_cnt = 0;
   int tick_cnt = 0;
   int pulse_at[$];
   int tick_at[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act,
                          input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic cmp(input string nm, input logic a, input logic e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL model %s cyc=%0d: dut=%b model=%b", nm, cyc, a, e);
      end
   endtask

   // Single compare point: every clock advance goes through here.
   task automatic tick1();
      @(negedge clk);
      cyc++;
      if (fire_pulse === 1'b1) begin
         pulse_cnt++;
         pulse_at.push_back(cyc);
      end
      if (fire_db === 1'b1) fdb_cnt++;
      if (ms_tick === 1'b1) begin
         tick_cnt++;
         tick_at.push_back(cyc);
      end
      cmp("up_db", up_db, m.db[0]);
      cmp("down_db", down_db, m.db[1]);
      cmp("fire_db", fire_db, m.db[2]);
      cmp("up_move", up_move, m.db[0] & ~m.db[1]);
      cmp("down_move", down_move, m.db[1] & ~m.db[0]);
      cmp("fire_pulse", fire_pulse, m.pulse);
      cmp("ms_tick", ms_tick, m.tick);
   endtask

   function automatic logic sig(input int s);
      case (s)
         0: return up_db;
         1: return down_db;
         2: return fire_db;
         default: return up_move;
      endcase
   endfunction

   task automatic wait_sig(input int s, input logic want,
                           input int maxc, output int n);
      n = 0;
      while (sig(s) !== want && n < maxc) begin
         tick1();
         n++;
      end
   endtask

   initial begin
      int n, t0, k0, q0, p0, f0;
      repeat (3) tick1();
      chk("rst_up_db", up_db, 0);
      chk("rst_fire_pulse", fire_pulse, 0);
      chk("rst_ms_tick", ms_tick, 0);
      reset = 1'b0;

      t0 = cyc;
      k0 = tick_cnt;
      q0 = tick_at.size();
      repeat (40) tick1();
      chk("ms_tick_count", tick_cnt - k0, 10);
      if (tick_at.size() > q0) chk("ms_tick_first", tick_at[q0] - t0, 4);
      for (int i = q0 + 1; i < tick_at.size(); i++)
         chk("ms_tick_gap", tick_at[i] - tick_at[i-1], 4);

      upButton = 1'b1;
      wait_sig(0, 1'b1, 20, n);
      chk_rng("up_press_lat", n, 11, 15);
      chk("up_move_on", up_move, 1);
      chk("down_move_off", down_move, 0);
      repeat (5) tick1();
      upButton = 1'b0;
      wait_sig(0, 1'b0, 20, n);
      chk_rng("up_release_lat", n, 11, 15);
      chk("up_move_off", up_move, 0);

      p0 = pulse_cnt;
      f0 = fdb_cnt;
      for (int i = 0; i < 12; i++) begin
         fireButton = ~fireButton;
         repeat (5) tick1();
      end
      chk("bounce_fire_db", fdb_cnt - f0, 0);
      chk("bounce_pulse", pulse_cnt - p0, 0);
      fireButton = 1'b1;
      wait_sig(2, 1'b1, 20, n);
      chk_rng("settle_lat", n, 11, 15);
      tick1();
      chk("settle_pulse_now", fire_pulse, 1);
      repeat (10) tick1();
      chk("settle_pulse_count", pulse_cnt - p0, 1);
      fireButton = 1'b0;
      wait_sig(2, 1'b0, 20, n);
      chk_rng("fire_release_lat", n, 11, 15);
      repeat (5) tick1();

      p0 = pulse_cnt;
      q0 = pulse_at.size();
      fireButton = 1'b1;
      repeat (200) tick1();
`ifdef BUTTON_AUTOFIRE_EN
      chk("autofire_count", pulse_cnt - p0, 10);
      for (int i = q0 + 2; i < pulse_at.size(); i++)
         chk("autofire_gap", pulse_at[i] - pulse_at[i-1], 20);
`else
      chk("held_single_pulse", pulse_cnt - p0, 1);
`endif
      fireButton = 1'b0;
      repeat (20) tick1();

      upButton = 1'b1;
      downButton = 1'b1;
      repeat (20) tick1();
      chk("both_up_db", up_db, 1);
      chk("both_down_db", down_db, 1);
      chk("both_up_move", up_move, 0);
      chk("both_down_move", down_move, 0);
      downButton = 1'b0;
      wait_sig(3, 1'b1, 20, n);
      chk_rng("up_after_down_rel", n, 11, 15);
      chk("down_db_released", down_db, 0);
      upButton = 1'b0;
      repeat (20) tick1();

      upButton = 1'b1;
      fireButton = 1'b1;
      repeat (22) tick1();
      chk("pre_rst_fire_db", fire_db, 1);
      chk("pre_rst_up_move", up_move, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_up_db", up_db, 0);
      chk("arst_down_db", down_db, 0);
      chk("arst_fire_db", fire_db, 0);
      chk("arst_up_move", up_move, 0);
      chk("arst_down_move", down_move, 0);
      chk("arst_fire_pulse", fire_pulse, 0);
      chk("arst_ms_tick", ms_tick, 0);
      repeat (2) tick1();
      upButton = 1'b0;
      reset = 1'b0;
      p0 = pulse_cnt;
      wait_sig(2, 1'b1, 20, n);
      chk_rng("post_rst_fire_lat", n, 11, 15);
      tick1();
      chk("post_rst_pulse", fire_pulse, 1);
      tick1();
      chk("post_rst_pulse_width", fire_pulse, 0);
      repeat (10) tick1();
      chk("post_rst_pulse_count", pulse_cnt - p0, 1);
      fireButton = 1'b0;
      repeat (20) tick1();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
